uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter, successor to the fixed 8N1 transmitter in the echo datapath. It accepts characters through a valid/ready handshake into a small internal FIFO and serialises them onto `UART_TX`. Data width, parity, stop-bit count and baud divisor are compile-time selectable. Queued characters go out back-to-back with no idle gap, so the echo path can burst without stalling on every character.

## Interface

Parameters:
- `DATA_BITS`, 8: character width, legal 5..8; LSB sent first.
- `PARITY`, 0: parity mode; 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: stop bits per frame, legal 1 or 2.
- `BAUD_DIV`, 10417: clocks per bit (100 MHz / 9600); legal ≥ 2.
- `FIFO_DEPTH`, 4: queued characters; power of two, ≥ 2.

Ports:
- `CLK` input 1: system clock.
- `RST_N` input 1: asynchronous active-low reset.
- `send` input 1: write strobe; character accepted on a rising edge where `send && ready`.
- `send_data` input DATA_BITS: character written with `send`.
- `ready` output 1: FIFO not full; registered.
- `busy` output 1: frame in progress or FIFO non-empty; registered.
- `UART_TX` output 1: serial line, idle high; registered.

## Operation

- **Reset values:** `UART_TX`=1, `ready`=1, `busy`=0, FIFO empty, FSM in IDLE, bit timer 0.
- **Reset mid-frame:** the frame is aborted. `UART_TX` goes to 1 asynchronously and queued data is discarded.
- **Write with `ready`=0:** ignored. The character is dropped and the FIFO is unchanged.
- **Full FIFO:** a push is refused even if a pop happens on the same edge. `ready` rises the cycle after the pop.
- **Frame:** start bit 0, then DATA_BITS data bits LSB first, then a parity bit if PARITY≠0, then STOP_BITS stop bits of 1.
- **Parity:**
  - Odd: the ones-count of data plus parity is odd.
  - Even: the ones-count is even.
  - The parity bit is computed from the latched character when the FIFO is popped.
- **FSM states:**
  - IDLE: line high. If FIFO non-empty, pop, latch the character into the shift register and go to START.
  - START: drive 0 for BAUD_DIV cycles, then go to DATA.
  - DATA: drive shift-register bit 0 for BAUD_DIV cycles per bit, shifting right after each bit. After DATA_BITS bits, go to PARITY if PARITY≠0, else STOP.
  - PARITY: drive the parity bit for BAUD_DIV cycles, then go to STOP.
  - STOP: drive 1 for STOP_BITS×BAUD_DIV cycles. On the last cycle:
    - if the FIFO is non-empty, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- **Counters:**
  - Bit timer is $clog2(BAUD_DIV) bits wide. It counts 0..BAUD_DIV-1 and clears on wrap and in IDLE.
  - Bit index is $clog2(DATA_BITS+1) bits wide; the stop counter is 1 bit.
  - FIFO pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally; full/empty are derived from MSB comparison.

## Timing

- Write accepted at edge k into an empty FIFO with the FSM in IDLE:
  - FIFO non-empty after edge k;
  - pop at edge k+1, with `UART_TX`=0 from edge k+1;
  - `busy`=1 from edge k+1.
- Each bit holds for exactly BAUD_DIV clocks.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × BAUD_DIV clocks.
- Consecutive queued frames are contiguous: the next start bit begins the clock after the final stop-bit clock.
- `busy` falls on the edge where the FSM enters IDLE with the FIFO empty.
- `ready` falls at the edge a push fills the FIFO. It rises one edge after the pop that frees a slot.

## Structure

- Shared package `uart_pkg`:
  - parity encodings `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - FSM state encodings IDLE/START/DATA/PARITY/STOP;
  - default `BAUD_DIV` constant 10417.
- Sub-module `uart_fifo`: synchronous, single clock, async active-low reset, parametrised width and depth, push/pop with full/empty flags.
- Top level: FSM, bit timer, shift register and parity generator.

## Test plan

Benches run with BAUD_DIV=4 unless stated.

- **8N1:** reset, write 0x55 → `UART_TX` sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 clocks, start bit low 1 clock after the accept edge; `busy` high for 40 clocks.
- **Parity, 8O1 and 8E2:** 0x07 in 8O1 → parity bit 0 after the data bits. 0x07 in 8E2 → parity bit 1, then 8 high stop clocks.
- **Width and ordering:** DATA_BITS=5, write 0x1F then 0x00 back-to-back → two 7-bit frames with no idle clocks between the first stop bit and the second start bit.
- **Overflow:** FIFO_DEPTH=4, 6 writes on consecutive clocks from idle → `ready`=0 after the 5th accept (one byte popped). The 6th write is dropped. Exactly 5 frames emerge, in order.
- **Reset mid-frame:** assert `RST_N`=0 during bit 3 of 0xA5 → `UART_TX`=1 immediately, `busy`=0, `ready`=1. No further frames after release.
- **Default divisor:** BAUD_DIV=10417, one byte → start bit width measured at exactly 10417 clocks.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared parity encodings, FSM states and default baud divisor for the UART transmitter
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD = 1;
  localparam int PAR_EVEN = 2;
  localparam int DEFAULT_BAUD_DIV = 10417;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: single-clock FIFO with registered full/empty flags derived from wrapped pointers
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd, w_wr_nx, w_rd_nx;
  logic w_push, w_pop;
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign w_wr_nx = r_wr + (AW+1)'(w_push);
  assign w_rd_nx = r_rd + (AW+1)'(w_pop);
  assign o_data = r_mem[r_rd[AW-1:0]];
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_wr <= '0;
      r_rd <= '0;
      o_full <= 1'b0;
      o_empty <= 1'b1;
    end else begin
      r_wr <= w_wr_nx;
      r_rd <= w_rd_nx;
      o_full <= (w_wr_nx[AW] != w_rd_nx[AW]) && (w_wr_nx[AW-1:0] == w_rd_nx[AW-1:0]);
      o_empty <= w_wr_nx == w_rd_nx;
    end
  always_ff @(posedge CLK)
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: FIFO-buffered UART transmitter with selectable width, parity and stop bits
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY = PAR_NONE,
  parameter int STOP_BITS = 1,
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] send_data,
  output logic                 ready,
  output logic                 busy,
  output logic                 UART_TX
);
  localparam int TW = $clog2(BAUD_DIV);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_LAST = TW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
  localparam logic S_LAST = 1'(STOP_BITS - 1);
  state_t r_state, w_state_nx;
  logic [TW-1:0] r_timer, w_timer_nx;
  logic [IW-1:0] r_bit_idx, w_bit_idx_nx;
  logic [DATA_BITS-1:0] r_shift, w_shift_nx, w_fifo_dout;
  logic r_stop_cnt, w_stop_cnt_nx, r_parity, w_parity_nx, r_tx, w_tx_nx, r_busy;
  logic w_pop, w_empty, w_full, w_bit_end;
  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK(CLK),
    .RST_N(RST_N),
    .i_push(send),
    .i_data(send_data),
    .i_pop(w_pop),
    .o_data(w_fifo_dout),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  assign w_bit_end = r_timer == T_LAST;
  assign ready = !w_full;
  assign busy = r_busy;
  assign UART_TX = r_tx;
  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = w_bit_end ? '0 : r_timer + 1'b1;
    w_bit_idx_nx = r_bit_idx;
    w_stop_cnt_nx = r_stop_cnt;
    w_shift_nx = r_shift;
    w_parity_nx = r_parity;
    w_pop = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_timer_nx = '0;
        w_pop = !w_empty;
      end
      S_START: if (w_bit_end) w_state_nx = S_DATA;
      S_DATA: if (w_bit_end) begin
        w_shift_nx = r_shift >> 1;
        w_bit_idx_nx = r_bit_idx + 1'b1;
        if (r_bit_idx == I_LAST) w_state_nx = PARITY != PAR_NONE ? S_PARITY : S_STOP;
      end
      S_PARITY: if (w_bit_end) w_state_nx = S_STOP;
      S_STOP: if (w_bit_end) begin
        w_stop_cnt_nx = r_stop_cnt == S_LAST ? 1'b0 : 1'b1;
        if (r_stop_cnt == S_LAST) begin
          w_pop = !w_empty;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    // a pop always launches a new frame, whether from IDLE or straight out of the last stop clock
    if (w_pop) begin
      w_state_nx = S_START;
      w_shift_nx = w_fifo_dout;
      w_parity_nx = (^w_fifo_dout) ^ (PARITY == PAR_ODD);
      w_bit_idx_nx = '0;
    end
    w_tx_nx = w_state_nx == S_START ? 1'b0 :
              w_state_nx == S_DATA ? w_shift_nx[0] :
              w_state_nx == S_PARITY ? w_parity_nx : 1'b1;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_bit_idx <= '0;
      r_stop_cnt <= 1'b0;
      r_shift <= '0;
      r_parity <= 1'b0;
      r_tx <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_timer <= w_timer_nx;
      r_bit_idx <= w_bit_idx_nx;
      r_stop_cnt <= w_stop_cnt_nx;
      r_shift <= w_shift_nx;
      r_parity <= w_parity_nx;
      r_tx <= w_tx_nx;
      r_busy <= w_state_nx != S_IDLE;
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed checks of framing, parity, back-to-back bursts, overflow, reset and default divisor
module tb_uart_tx_frame;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic send = 1'b0;
  logic [7:0] data = 8'h00;
  logic [2:0] sel = 3'd0;
  logic tx_v [5];
  logic busy_v [5];
  logic ready_v [5];
  logic tx_m, busy_m, ready_m;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  assign tx_m = tx_v[sel];
  assign busy_m = busy_v[sel];
  assign ready_m = ready_v[sel];
  uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .BAUD_DIV(4), .FIFO_DEPTH(4)) u_a (
    .CLK(clk), .RST_N(rst_n), .send(send && sel == 3'd0), .send_data(data),
    .ready(ready_v[0]), .busy(busy_v[0]), .UART_TX(tx_v[0]));
  uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .BAUD_DIV(4), .FIFO_DEPTH(4)) u_o (
    .CLK(clk), .RST_N(rst_n), .send(send && sel == 3'd1), .send_data(data),
    .ready(ready_v[1]), .busy(busy_v[1]), .UART_TX(tx_v[1]));
  uart_tx_frame #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .BAUD_DIV(4), .FIFO_DEPTH(4)) u_e (
    .CLK(clk), .RST_N(rst_n), .send(send && sel == 3'd2), .send_data(data),
    .ready(ready_v[2]), .busy(busy_v[2]), .UART_TX(tx_v[2]));
  uart_tx_frame #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .BAUD_DIV(4), .FIFO_DEPTH(4)) u_w (
    .CLK(clk), .RST_N(rst_n), .send(send && sel == 3'd3), .send_data(data[4:0]),
    .ready(ready_v[3]), .busy(busy_v[3]), .UART_TX(tx_v[3]));
  uart_tx_frame u_d (
    .CLK(clk), .RST_N(rst_n), .send(send && sel == 3'd4), .send_data(data),
    .ready(ready_v[4]), .busy(busy_v[4]), .UART_TX(tx_v[4]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] d);
    data = d;
    send = 1'b1;
    step();
    send = 1'b0;
  endtask
  task automatic expect_frame(input string tag, input logic [15:0] bits, input int nbits);
    for (int i = 0; i < nbits * 4; i++) begin
      check(tag, tx_m, bits[i/4]);
      check({tag, "_busy"}, busy_m, 1);
      step();
    end
  endtask
  initial begin
    logic [7:0] d [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'hC3};
    logic qtx [241];
    logic qrdy [241];
    logic [15:0] fb;
    int lows;
    int cnt;
    repeat (3) step();
    check("rst_tx", tx_m, 1);
    check("rst_ready", ready_m, 1);
    check("rst_busy", busy_m, 0);
    rst_n = 1'b1;
    step();
    push(8'h55);
    check("8n1_tx_accept", tx_m, 1);
    check("8n1_busy_accept", busy_m, 0);
    step();
    expect_frame("8n1", 16'h02AA, 10);
    check("8n1_busy_end", busy_m, 0);
    check("8n1_tx_end", tx_m, 1);
    sel = 3'd1;
    push(8'h07);
    step();
    expect_frame("8o1", 16'h040E, 11);
    check("8o1_busy_end", busy_m, 0);
    sel = 3'd2;
    push(8'h07);
    step();
    expect_frame("8e2", 16'h0E0E, 12);
    check("8e2_busy_end", busy_m, 0);
    sel = 3'd3;
    push(8'h1F);
    push(8'h00);
    expect_frame("5n1_a", 16'h007E, 7);
    expect_frame("5n1_b", 16'h0040, 7);
    check("5n1_busy_end", busy_m, 0);
    check("5n1_tx_end", tx_m, 1);
    sel = 3'd0;
    step();
    for (int j = 0; j < 241; j++) begin
      send = j < 6;
      data = j < 6 ? d[j] : 8'h00;
      step();
      qtx[j] = tx_m;
      qrdy[j] = ready_m;
    end
    send = 1'b0;
    for (int j = 0; j < 6; j++) check($sformatf("ovf_ready_%0d", j), qrdy[j], j < 4);
    check("ovf_ready_before_pop", qrdy[40], 0);
    check("ovf_ready_after_pop", qrdy[41], 1);
    for (int f = 0; f < 5; f++) begin
      fb = {6'b0, 1'b1, d[f], 1'b0};
      for (int b = 0; b < 10; b++) check($sformatf("ovf_f%0d_b%0d", f, b), qtx[f*40+b*4+2], fb[b]);
    end
    lows = 0;
    for (int j = 201; j < 241; j++) lows += qtx[j] ? 0 : 1;
    check("ovf_no_sixth_frame", lows, 0);
    check("ovf_busy_end", busy_m, 0);
    push(8'hA5);
    repeat (18) step();
    check("rst_mid_tx_before", tx_m, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tx", tx_m, 1);
    check("rst_mid_busy", busy_m, 0);
    check("rst_mid_ready", ready_m, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    lows = 0;
    for (int j = 0; j < 60; j++) begin
      step();
      lows += (tx_m == 1'b0 || busy_m == 1'b1) ? 1 : 0;
    end
    check("rst_mid_quiet", lows, 0);
    sel = 3'd4;
    push(8'hA5);
    step();
    cnt = 0;
    while (tx_m == 1'b0 && cnt < 20000) begin
      cnt++;
      step();
    end
    check("default_start_width", cnt, 10417);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
